hazard_unit: RTL and testbench

//  Hazard detection/forwarding control for the 5-stage MIPS pipeline (F/D/E/M/W).

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_fwd_sel.sv | 29 ++
 rtl/hazard_unit.sv | 112 +++++++++++
 tb/tb_hazard_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: register address type,
// the hard-wired zero register and the Execute operand select encoding.
package hazard_pkg;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Bypass select for one Execute-stage ALU operand.
// The Memory stage holds the younger result, so it wins over Writeback.
// Register 0 is hard-wired and never takes a bypass.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  output fwd_sel_e         sel
);

  // Pick the youngest in-flight producer of src, if any.
  always_comb begin
    sel = FWD_NONE;
    if (src != REG_W'(REG_ZERO)) begin
      if (regwriteM && (src == writeregM)) begin
        sel = FWD_MEM;
      end else if (regwriteW && (src == writeregW)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// All forwarding and stall outputs are combinational. While reset is high
// the forwards are forced off, stalls are released and E is flushed.
// Optional feature: define HAZARD_PERF_EN to add load-use and branch stall
// cycle counters (lw_stall_cnt, br_stall_cnt).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             bneD,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt
`endif
);

  fwd_sel_e faSel;
  fwd_sel_e fbSel;
  logic     lwStall;
  logic     branchStall;

  hazard_fwd_sel #(.REG_W(REG_W)) uFwdA (
    .src       (rsE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .sel       (faSel)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) uFwdB (
    .src       (rtE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .sel       (fbSel)
  );

  // Raw hazard conditions; a load in E or a result not yet ready for the branch compare.
  always_comb begin
    lwStall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
    branchStall = (branchD || bneD) &&
                  ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                   (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  end

  // Output drive with reset override: both stall causes collapse into one bubble.
  always_comb begin
    forwardaD = 1'b0;
    forwardbD = 1'b0;
    forwardaE = FWD_NONE;
    forwardbE = FWD_NONE;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushE    = 1'b1;
    if (!reset) begin
      forwardaD = (rsD != REG_W'(REG_ZERO)) && (rsD == writeregM) && regwriteM;
      forwardbD = (rtD != REG_W'(REG_ZERO)) && (rtD == writeregM) && regwriteM;
      forwardaE = faSel;
      forwardbE = fbSel;
      stallF    = lwStall || branchStall;
      stallD    = lwStall || branchStall;
      flushE    = lwStall || branchStall;
    end
  end

`ifdef HAZARD_PERF_EN
  // Stall-cycle counters; both causes may count in the same cycle, wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      lw_stall_cnt <= '0;
      br_stall_cnt <= '0;
    end else begin
      if (lwStall)     lw_stall_cnt <= lw_stall_cnt + CNT_W'(1);
      if (branchStall) br_stall_cnt <= br_stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unusedClk;
  assign unusedClk = clk;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed cases from the pipeline
// scenarios plus randomized stimulus compared against a rule-level model.
// Counter checks are built when HAZARD_PERF_EN is defined.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, bneD;
  logic       forwardaD, forwardbD, stallF, stallD, flushE;
  logic [1:0] forwardaE, forwardbE;
`ifdef HAZARD_PERF_EN
  logic [31:0] lwCnt, brCnt;
  int          expLw = 0;
  int          expBr = 0;
`endif

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk       (clk),
    .reset     (reset),
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregE (writeregE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteE (regwriteE),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .memtoregE (memtoregE),
    .memtoregM (memtoregM),
    .branchD   (branchD),
    .bneD      (bneD),
    .forwardaD (forwardaD),
    .forwardbD (forwardbD),
    .forwardaE (forwardaE),
    .forwardbE (forwardbE),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushE    (flushE)
`ifdef HAZARD_PERF_EN
    ,
    .lw_stall_cnt (lwCnt),
    .br_stall_cnt (brCnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outVec();
    return {23'd0, forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, flushE};
  endfunction

  // Execute operand source number: 2 = M result, 1 = W result, 0 = register file.
  function automatic int refFwdE(int src);
    if (src == 0) return 0;
    if (regwriteM && src == int'(writeregM)) return 2;
    if (regwriteW && src == int'(writeregW)) return 1;
    return 0;
  endfunction

  function automatic bit refLw();
    return memtoregE && (rtE == rsD || rtE == rtD);
  endfunction

  function automatic bit refBr();
    bit depE, depM;
    depE = regwriteE && (writeregE == rsD || writeregE == rtD);
    depM = memtoregM && (writeregM == rsD || writeregM == rtD);
    return (branchD || bneD) && (depE || depM);
  endfunction

  function automatic logic [31:0] refVec();
    int faD, fbD, faE, fbE, st;
    if (reset) return 32'd1;
    faD = (rsD != 0 && rsD == writeregM && regwriteM) ? 1 : 0;
    fbD = (rtD != 0 && rtD == writeregM && regwriteM) ? 1 : 0;
    faE = refFwdE(int'(rsE));
    fbE = refFwdE(int'(rtE));
    st  = (refLw() || refBr()) ? 1 : 0;
    return 32'(faD * 256 + fbD * 128 + faE * 32 + fbE * 8 + st * 7);
  endfunction

  task automatic clearInputs();
    reset = 0;
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, bneD} = '0;
  endtask

  // Vector layout: {faD,fbD,faE[1:0],fbE[1:0],stallF,stallD,flushE}
  initial begin
    clearInputs();
    reset = 1;
    @(negedge clk);
    #1 check("reset_idle", outVec(), 32'b0_0_00_00_0_0_1);

    @(negedge clk);
    clearInputs();
    rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    #1 check("m_over_w", outVec(), 32'b0_0_10_00_0_0_0);

    clearInputs();
    rtE = 5; writeregW = 5; regwriteW = 1;
    #1 check("w_fwd_b", outVec(), 32'b0_0_00_01_0_0_0);

    clearInputs();
    rsD = 1; rtD = 2; memtoregE = 1; rtE = 7; rsD = 7;
    #1 check("lw_rs", outVec(), 32'b0_0_00_00_1_1_1);

    rsD = 1; rtD = 7;
    #1 check("lw_rt", outVec(), 32'b0_0_00_00_1_1_1);

    clearInputs();
    rtD = 9; branchD = 1; rsD = 4; writeregE = 4; regwriteE = 1;
    #1 check("br_e_dep", outVec(), 32'b0_0_00_00_1_1_1);

    clearInputs();
    rsD = 11; bneD = 1; rtD = 6; memtoregM = 1; writeregM = 6; regwriteM = 1;
    #1 check("bne_m_dep", outVec(), 32'b0_1_00_00_1_1_1);

    clearInputs();
    rsE = 0; writeregM = 0; regwriteM = 1; rtE = 1; rtD = 1;
    #1 check("zero_reg", outVec(), 32'b0_0_00_00_0_0_0);

    clearInputs();
    rsD = 2; rtD = 2; rtE = 2; memtoregE = 1; branchD = 1; writeregE = 2; regwriteE = 1;
    #1 check("both_stall", outVec(), 32'b0_0_00_00_1_1_1);

    reset = 1;
    #1 check("reset_override", outVec(), 32'b0_0_00_00_0_0_1);

`ifdef HAZARD_PERF_EN
    @(posedge clk);
    #1 check("cnt_lw_rst", lwCnt, 32'd0);
    @(negedge clk);
    clearInputs();
    memtoregE = 1; rtE = 7; rsD = 7; rtD = 1;
    repeat (3) @(posedge clk);
    #1 check("cnt_lw_3", lwCnt, 32'd3);
    check("cnt_br_0", brCnt, 32'd0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 check("cnt_lw_clr", lwCnt, 32'd0);
    expLw = 0; expBr = 0;
`endif

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 9) == 0);
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = 1'($urandom_range(0, 1));
      memtoregM = 1'($urandom_range(0, 1));
      branchD   = ($urandom_range(0, 3) == 0);
      bneD      = ($urandom_range(0, 3) == 0);
      #1 check("rand_vec", outVec(), refVec());
`ifdef HAZARD_PERF_EN
      if (reset) begin
        expLw = 0; expBr = 0;
      end else begin
        if (refLw()) expLw++;
        if (refBr()) expBr++;
      end
      @(posedge clk);
      #1;
      check("rand_lw_cnt", lwCnt, 32'(expLw));
      check("rand_br_cnt", brCnt, 32'(expBr));
`endif
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
